// File: rtl/fft_sample_loader.sv
// fft_sample_loader: feeds unsigned ADC samples into FFT RAM 0 as complex
// Q1.15 words at bit-reversed (or natural) addresses, kicks off the transform
// once a frame is complete, then waits for the result to be drained before
// accepting the next frame.
module fft_sample_loader #(
    parameter int N            = 64,
    parameter int ADC_W        = 12,
    parameter int BIT_REVERSE  = 1,
    parameter int DRAIN_CYCLES = 128
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADC_W-1:0]       sample_in,
    input  logic                   sample_valid,
    output logic                   sample_ready,
    output logic                   fft_load,
    output logic [$clog2(N)-1:0]   fft_load_address,
    output logic [31:0]            fft_data,
    output logic                   fft_start,
    input  logic                   fft_done,
    output logic                   frame_done,
    output logic                   busy
);

    localparam int AW = $clog2(N);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [AW-1:0] LAST_SAMPLE = AW'(N - 1);
    localparam logic [DW-1:0] LAST_DRAIN  = DW'(DRAIN_CYCLES - 1);
    localparam logic [ADC_W-1:0] SIGN_FLIP = ADC_W'(1) << (ADC_W - 1);

    typedef enum logic [1:0] {
        FILL,
        START,
        WAIT_DONE,
        DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   sampleCount_q, sampleCount_d;
    logic [DW-1:0]   drainCount_q, drainCount_d;
    logic            seenLow_q, seenLow_d;
    logic            ready_q, ready_d;
    logic            load_q, load_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     data_q, data_d;
    logic            start_q, start_d;

    logic [ADC_W-1:0] sampleSigned;
    logic [15:0]      sampleRe;

    // Maps a sample index to its RAM address; reversal lets the FFT run in place
    function automatic logic [AW-1:0] addrOf(input logic [AW-1:0] k);
        logic [AW-1:0] r;
        r = k;
        if (BIT_REVERSE != 0) begin
            for (int i = 0; i < AW; i++) begin
                r[i] = k[AW-1-i];
            end
        end
        return r;
    endfunction

    // Offset-binary to two's complement is just an MSB flip; then left-justify into Q1.15
    assign sampleSigned = sample_in ^ SIGN_FLIP;
    assign sampleRe     = 16'(sampleSigned) << (16 - ADC_W);

    // Next-state and registered-output logic for the frame sequencing FSM
    always_comb begin
        state_d       = state_q;
        sampleCount_d = sampleCount_q;
        drainCount_d  = drainCount_q;
        seenLow_d     = seenLow_q;
        load_d        = 1'b0;
        addr_d        = addr_q;
        data_d        = data_q;
        start_d       = 1'b0;
        case (state_q)
            FILL: begin
                if (sample_valid && ready_q) begin
                    load_d = 1'b1;
                    addr_d = addrOf(sampleCount_q);
                    data_d = {sampleRe, 16'h0000};
                    if (sampleCount_q == LAST_SAMPLE) begin
                        state_d = START;
                    end else begin
                        sampleCount_d = sampleCount_q + AW'(1);
                    end
                end
            end
            START: begin
                start_d   = 1'b1;
                seenLow_d = 1'b0;
                state_d   = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!fft_done) begin
                    seenLow_d = 1'b1;
                end else if (seenLow_q) begin
                    state_d      = DRAIN;
                    drainCount_d = '0;
                end
            end
            DRAIN: begin
                drainCount_d = drainCount_q + DW'(1);
                if (drainCount_q == LAST_DRAIN) begin
                    state_d       = FILL;
                    sampleCount_d = '0;
                    drainCount_d  = '0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
        ready_d = (state_d == FILL);
    end

    // State and output registers; reset abandons any partial frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= FILL;
            sampleCount_q <= '0;
            drainCount_q  <= '0;
            seenLow_q     <= 1'b0;
            ready_q       <= 1'b0;
            load_q        <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            start_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            sampleCount_q <= sampleCount_d;
            drainCount_q  <= drainCount_d;
            seenLow_q     <= seenLow_d;
            ready_q       <= ready_d;
            load_q        <= load_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            start_q       <= start_d;
        end
    end

    assign sample_ready     = ready_q;
    assign fft_load         = load_q;
    assign fft_load_address = addr_q;
    assign fft_data         = data_q;
    assign fft_start        = start_q;
    assign frame_done       = (state_q == DRAIN) && (drainCount_q == LAST_DRAIN);
    assign busy             = (state_q != FILL);

endmodule

// File: tb/tb_fft_sample_loader.sv
// Testbench for fft_sample_loader: drives frames of ADC samples and checks the
// RAM write stream, start pulse and drain timing against a frame-level model.
module tb_fft_sample_loader;

    localparam int N     = 64;
    localparam int ADC_W = 12;
    localparam int DC    = 128;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        fft_done = 1'b0;

    logic        sampleReady, fftLoad, fftStart, frameDone, busy;
    logic [5:0]  fftAddr;
    logic [31:0] fftData;

    logic        natReady, natLoad, natStart, natFrameDone, natBusy;
    logic [5:0]  natAddr;
    logic [31:0] natData;

    int vectors = 0;
    int miscompares = 0;

    logic [11:0] frameData [N];
    logic [5:0]  lastAddr, lastNat;
    logic [31:0] lastData;

    fft_sample_loader #(.N(N), .ADC_W(ADC_W), .BIT_REVERSE(1), .DRAIN_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
        .sample_ready(sampleReady), .fft_load(fftLoad), .fft_load_address(fftAddr),
        .fft_data(fftData), .fft_start(fftStart), .fft_done(fft_done),
        .frame_done(frameDone), .busy(busy)
    );

    fft_sample_loader #(.N(N), .ADC_W(ADC_W), .BIT_REVERSE(0), .DRAIN_CYCLES(DC)) dutNat (
        .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
        .sample_ready(natReady), .fft_load(natLoad), .fft_load_address(natAddr),
        .fft_data(natData), .fft_start(natStart), .fft_done(fft_done),
        .frame_done(natFrameDone), .busy(natBusy)
    );

    // Free-running system clock
    always #5 clk = ~clk;

    function automatic logic [5:0] bitrev(input int k);
        int r;
        r = 0;
        for (int i = 0; i < 6; i++) begin
            if (k[i]) r = r | (1 << (5 - i));
        end
        return 6'(r);
    endfunction

    function automatic logic [31:0] packSample(input int x);
        int s;
        s = (x - 2048) * 16;
        return {16'(s), 16'h0000};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        sample_valid = 1'b1;
        reset = 1'b1;
        #1;
        checkOutput("rst_load", fftLoad, 1'b0);
        checkOutput("rst_start", fftStart, 1'b0);
        checkOutput("rst_addr", fftAddr, 6'd0);
        checkOutput("rst_data", fftData, 32'd0);
        checkOutput("rst_ready", sampleReady, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_fdone", frameDone, 1'b0);
        checkOutput("rst_nat_addr", natAddr, 6'd0);
        lastAddr = '0;
        lastNat  = '0;
        lastData = '0;
        repeat (2) begin
            tick();
            checkOutput("rst_hold_start", fftStart, 1'b0);
            checkOutput("rst_hold_load", fftLoad, 1'b0);
        end
        #2;
        reset = 1'b0;
        #1;
        checkOutput("ready_before_edge", sampleReady, 1'b0);
        tick();
        checkOutput("ready_after_edge", sampleReady, 1'b1);
        checkOutput("load_after_release", fftLoad, 1'b0);
        checkOutput("busy_after_release", busy, 1'b0);
    endtask

    task automatic applyStimulus(input int mode, input int limit);
        int   k;
        int   cyc;
        logic v;
        k = 0;
        cyc = 0;
        while (k < limit && cyc < 400) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            sample_valid = v;
            sample_in    = frameData[k];
            checkOutput("ready_fill", sampleReady, 1'b1);
            checkOutput("busy_fill", busy, 1'b0);
            tick();
            cyc++;
            if (v) begin
                lastAddr = bitrev(k);
                lastNat  = 6'(k);
                lastData = packSample(int'(frameData[k]));
                k++;
            end
            checkOutput("load", fftLoad, v);
            checkOutput("addr", fftAddr, lastAddr);
            checkOutput("addr_nat", natAddr, lastNat);
            checkOutput("data", fftData, lastData);
            checkOutput("data_nat", natData, lastData);
            checkOutput("start_in_fill", fftStart, 1'b0);
        end
        if (k < limit) checkOutput("fill_timeout", k, limit);
    endtask

    task automatic finishFrame();
        checkOutput("ready_after_last", sampleReady, 1'b0);
        checkOutput("busy_after_last", busy, 1'b1);
        sample_valid = 1'b1;
        tick();
        checkOutput("start_pulse", fftStart, 1'b1);
        checkOutput("start_nat", natStart, 1'b1);
        checkOutput("load_with_start", fftLoad, 1'b0);
        checkOutput("ready_start", sampleReady, 1'b0);
        tick();
        checkOutput("start_once", fftStart, 1'b0);
        checkOutput("no_extra_load", fftLoad, 1'b0);
    endtask

    task automatic waitAndDrain(input int holdCycles, input logic holdLevel, input bit pulseLow);
        int n;
        fft_done = holdLevel;
        for (int i = 0; i < holdCycles; i++) begin
            tick();
            checkOutput("wait_ready", sampleReady, 1'b0);
            checkOutput("wait_load", fftLoad, 1'b0);
            checkOutput("wait_fdone", frameDone, 1'b0);
            checkOutput("wait_busy", busy, 1'b1);
        end
        if (pulseLow) begin
            fft_done = 1'b0;
            tick();
            checkOutput("low_fdone", frameDone, 1'b0);
        end
        fft_done = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            checkOutput("drain_ready", sampleReady, 1'b0);
        end while (!frameDone && n < 4 * DC);
        checkOutput("drain_len", n, DC);
        checkOutput("drain_nat_fdone", natFrameDone, 1'b1);
        tick();
        checkOutput("fdone_pulse", frameDone, 1'b0);
        checkOutput("ready_return", sampleReady, 1'b1);
        checkOutput("busy_return", busy, 1'b0);
    endtask

    // Directed sequence of frames with randomized samples and gaps
    initial begin
        doReset();

        for (int k = 0; k < N; k++) frameData[k] = 12'(k);
        applyStimulus(0, N);
        finishFrame();
        waitAndDrain(50, 1'b0, 1'b0);

        applyStimulus(1, N);
        finishFrame();
        waitAndDrain(10, 1'b1, 1'b1);

        for (int k = 0; k < N; k++) frameData[k] = 12'($urandom_range(0, 4095));
        applyStimulus(2, N);
        finishFrame();
        waitAndDrain(5, 1'b0, 1'b0);

        for (int k = 0; k < N; k++) frameData[k] = 12'($urandom_range(0, 4095));
        applyStimulus(0, 20);
        doReset();
        applyStimulus(0, N);
        finishFrame();
        waitAndDrain(3, 1'b0, 1'b0);

        doReset();
        for (int k = 0; k < N; k++) frameData[k] = 12'($urandom_range(0, 4095));
        frameData[0] = 12'h000;
        frameData[1] = 12'h800;
        frameData[2] = 12'hFFF;
        applyStimulus(2, N);
        finishFrame();
        waitAndDrain(4, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
